// File: rtl/guvm_inst_sequencer.sv
// rtl/guvm_inst_sequencer.sv - request FIFO plus cycle-counted issue/pad/store-wait sequencer for the integer unit
module guvm_inst_sequencer #(
    parameter int          DEPTH         = 4,
    parameter int          PAD_CYCLES    = 4,
    parameter int          STORE_TIMEOUT = 8,
    parameter logic [31:0] NOP_WORD      = 32'h01000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [31:0] req_inst,
    input  logic [31:0] req_ldata,
    output logic [31:0] inst_out,
    output logic [31:0] ldata_out,
    input  logic        dmem_wr,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        res_valid,
    output logic        res_err,
    output logic [31:0] res_addr,
    output logic [31:0] res_data,
    output logic        busy,
    output logic        stray_wr
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (PAD_CYCLES > STORE_TIMEOUT) ? PAD_CYCLES : STORE_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [1:0] K_ALU   = 2'd0;
    localparam logic [1:0] K_LOAD  = 2'd1;
    localparam logic [1:0] K_STORE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_PAD,
        S_SWAIT
    } state_t;

    // Request FIFO storage and pointers
    logic [1:0]  r_fifo_kind  [DEPTH];
    logic [31:0] r_fifo_inst  [DEPTH];
    logic [31:0] r_fifo_ldata [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // Sequencer state and registered outputs
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_captured;
    logic [1:0]    r_cur_kind;
    logic [31:0]   r_inst_out;
    logic [31:0]   r_ldata_out;
    logic          r_res_valid;
    logic          r_res_err;
    logic [31:0]   r_res_addr;
    logic [31:0]   r_res_data;
    logic          r_stray;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_is_store;
    logic          w_cap;
    logic          w_pad_end;
    logic          w_sw_to;
    logic          w_need_wait;
    logic          w_leave;
    logic          w_stray;
    logic [1:0]    w_head_kind;
    logic [31:0]   w_head_inst;
    logic [31:0]   w_head_ldata;

    // Occupancy, capture and transition decisions shared by the FIFO and the FSM
    always_comb begin
        w_full       = (r_count == (AW+1)'(DEPTH));
        w_empty      = (r_count == '0);
        w_push       = req_valid && !w_full;
        w_is_store   = (r_cur_kind == K_STORE);
        // A store is captured only once; later strobes in the same transaction are dropped
        w_cap        = ((r_state == S_PAD) || (r_state == S_SWAIT)) && w_is_store
                       && !r_captured && dmem_wr;
        w_pad_end    = (r_state == S_PAD) && (r_cnt == CW'(PAD_CYCLES - 1));
        w_sw_to      = (r_state == S_SWAIT) && (r_cnt == CW'(STORE_TIMEOUT - 1));
        // A capture on the last pad cycle counts, so no wait is needed then
        w_need_wait  = w_is_store && !r_captured && !w_cap;
        w_leave      = (w_pad_end && !w_need_wait)
                       || ((r_state == S_SWAIT) && (w_cap || w_sw_to));
        w_pop        = !w_empty && ((r_state == S_IDLE) || w_leave);
        w_stray      = dmem_wr && ((r_state == S_IDLE) || (r_state == S_ISSUE)
                       || (((r_state == S_PAD) || (r_state == S_SWAIT)) && !w_is_store));
        w_head_kind  = r_fifo_kind[r_rd_ptr];
        w_head_inst  = r_fifo_inst[r_rd_ptr];
        w_head_ldata = r_fifo_ldata[r_rd_ptr];
    end

    // FIFO entry writes; contents need no reset since occupancy guards every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_kind[r_wr_ptr]  <= req_kind;
            r_fifo_inst[r_wr_ptr]  <= req_inst;
            r_fifo_ldata[r_wr_ptr] <= req_ldata;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue/pad/store-wait FSM with registered core-facing outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_captured  <= 1'b0;
            r_cur_kind  <= K_ALU;
            r_inst_out  <= NOP_WORD;
            r_ldata_out <= '0;
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
            r_res_addr  <= '0;
            r_res_data  <= '0;
            r_stray     <= 1'b0;
        end else begin
            r_inst_out  <= NOP_WORD;
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;

            if (w_stray) r_stray <= 1'b1;

            if (w_cap) begin
                r_res_addr  <= dmem_addr;
                r_res_data  <= dmem_wdata;
                r_res_valid <= 1'b1;
                r_captured  <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_ISSUE: begin
                    r_cnt      <= '0;
                    r_captured <= 1'b0;
                    r_state    <= S_PAD;
                end
                S_PAD: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_pad_end) begin
                        if (w_need_wait) begin
                            r_state <= S_SWAIT;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_SWAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_cap || w_sw_to) begin
                        r_state <= S_IDLE;
                    end
                    if (w_sw_to && !w_cap) begin
                        r_res_valid <= 1'b1;
                        r_res_err   <= 1'b1;
                        r_res_addr  <= '0;
                        r_res_data  <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A pop overrides the IDLE fallback so back-to-back work skips the idle bubble
            if (w_pop) begin
                r_state    <= S_ISSUE;
                r_inst_out <= w_head_inst;
                r_cur_kind <= (w_head_kind == K_LOAD)  ? K_LOAD  :
                              (w_head_kind == K_STORE) ? K_STORE : K_ALU;
                if (w_head_kind == K_LOAD) r_ldata_out <= w_head_ldata;
            end
        end
    end

    assign req_ready = !w_full;
    assign inst_out  = r_inst_out;
    assign ldata_out = r_ldata_out;
    assign res_valid = r_res_valid;
    assign res_err   = r_res_err;
    assign res_addr  = r_res_addr;
    assign res_data  = r_res_data;
    assign busy      = (r_state != S_IDLE) || !w_empty;
    assign stray_wr  = r_stray;

endmodule

// File: tb/tb_guvm_inst_sequencer.sv
// tb/tb_guvm_inst_sequencer.sv - vector-table and directed-sequence bench for guvm_inst_sequencer
module tb_guvm_inst_sequencer;

    localparam logic [31:0] NOP = 32'h01000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [31:0] req_inst;
    logic [31:0] req_ldata;
    logic [31:0] inst_out;
    logic [31:0] ldata_out;
    logic        dmem_wr;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        res_valid;
    logic        res_err;
    logic [31:0] res_addr;
    logic [31:0] res_data;
    logic        busy;
    logic        stray_wr;

    int n_vec = 0;
    int n_err = 0;

    guvm_inst_sequencer #(
        .DEPTH(4), .PAD_CYCLES(4), .STORE_TIMEOUT(8), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_inst(req_inst), .req_ldata(req_ldata),
        .inst_out(inst_out), .ldata_out(ldata_out),
        .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .res_valid(res_valid), .res_err(res_err), .res_addr(res_addr), .res_data(res_data),
        .busy(busy), .stray_wr(stray_wr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        mon_en = 1'b0;
    logic [31:0] mon_val[$];
    int          mon_cyc[$];
    always @(negedge clk) begin
        if (mon_en && inst_out != NOP) begin
            mon_val.push_back(inst_out);
            mon_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic        v;
        logic [1:0]  k;
        logic [31:0] inst;
        logic [31:0] ld;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] e_inst;
        logic [31:0] e_ld;
        logic        e_busy;
        logic        e_rv;
        logic        e_re;
        logic [31:0] e_ra;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [1:0] k, input logic [31:0] inst,
                       input logic [31:0] ld, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] e_inst, input logic [31:0] e_ld,
                       input logic e_busy, input logic e_rv, input logic e_re,
                       input logic [31:0] e_ra, input logic [31:0] e_rd);
        vec_t t;
        t = '{v, k, inst, ld, wr, addr, wd, e_inst, e_ld, e_busy, e_rv, e_re, e_ra, e_rd};
        vecs.push_back(t);
    endtask

    task automatic add_idle(input int n, input logic [31:0] e_inst, input logic [31:0] e_ld,
                            input logic e_busy, input logic [31:0] e_ra, input logic [31:0] e_rd);
        for (int j = 0; j < n; j++)
            add(0, 0, 0, 0, 0, 0, 0, e_inst, e_ld, e_busy, 0, 0, e_ra, e_rd);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_valid  = 1'b0;
        req_kind   = 2'd0;
        req_inst   = '0;
        req_ldata  = '0;
        dmem_wr    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
    endtask

    initial begin
        int n_rv;
        int c;

        // ALU issue, then 4 NOP pad cycles, then idle
        add(1, 0, 32'h82004003, 0, 0, 0, 0, NOP, 0, 1, 0, 0, 0, 0);
        add_idle(1, 32'h82004003, 0, 1, 0, 0);
        add_idle(4, NOP, 0, 1, 0, 0);
        add_idle(1, NOP, 0, 0, 0, 0);
        // LOAD followed by queued ALU: back-to-back issue, ldata held
        add(1, 1, 32'hC2002000, 32'hDEADBEEF, 0, 0, 0, NOP, 0, 1, 0, 0, 0, 0);
        add(1, 0, 32'h80102001, 0, 0, 0, 0, 32'hC2002000, 32'hDEADBEEF, 1, 0, 0, 0, 0);
        add_idle(4, NOP, 32'hDEADBEEF, 1, 0, 0);
        add_idle(1, 32'h80102001, 32'hDEADBEEF, 1, 0, 0);
        add_idle(4, NOP, 32'hDEADBEEF, 1, 0, 0);
        add_idle(1, NOP, 32'hDEADBEEF, 0, 0, 0);
        // STORE captured on third pad cycle, second strobe ignored
        add(1, 2, 32'hC2202010, 0, 0, 0, 0, NOP, 32'hDEADBEEF, 1, 0, 0, 0, 0);
        add_idle(1, 32'hC2202010, 32'hDEADBEEF, 1, 0, 0);
        add_idle(3, NOP, 32'hDEADBEEF, 1, 0, 0);
        add(0, 0, 0, 0, 1, 32'h40000010, 32'h12345678, NOP, 32'hDEADBEEF, 1, 1, 0,
            32'h40000010, 32'h12345678);
        add(0, 0, 0, 0, 1, 32'h40000020, 32'hAAAAAAAA, NOP, 32'hDEADBEEF, 0, 0, 0,
            32'h40000010, 32'h12345678);
        add_idle(1, NOP, 32'hDEADBEEF, 0, 32'h40000010, 32'h12345678);

        // Reset
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        chk("reset inst_out", inst_out, NOP);
        chk("reset ldata_out", ldata_out, 0);
        chk("reset res_valid", 32'(res_valid), 0);
        chk("reset res_err", 32'(res_err), 0);
        chk("reset res_addr", res_addr, 0);
        chk("reset res_data", res_data, 0);
        chk("reset stray_wr", 32'(stray_wr), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset req_ready", 32'(req_ready), 1);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            req_valid  = vecs[i].v;
            req_kind   = vecs[i].k;
            req_inst   = vecs[i].inst;
            req_ldata  = vecs[i].ld;
            dmem_wr    = vecs[i].wr;
            dmem_addr  = vecs[i].addr;
            dmem_wdata = vecs[i].wd;
            tick();
            chk($sformatf("v%0d inst_out", i), inst_out, vecs[i].e_inst);
            chk($sformatf("v%0d ldata_out", i), ldata_out, vecs[i].e_ld);
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d res_valid", i), 32'(res_valid), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d res_err", i), 32'(res_err), 32'(vecs[i].e_re));
            chk($sformatf("v%0d res_addr", i), res_addr, vecs[i].e_ra);
            chk($sformatf("v%0d res_data", i), res_data, vecs[i].e_rd);
            chk($sformatf("v%0d stray_wr", i), 32'(stray_wr), 0);
        end
        idle_inputs();

        // STORE with no write strobe: error result after 4 pad + 8 wait cycles
        req_valid = 1'b1;
        req_kind  = 2'd2;
        req_inst  = 32'hC2202020;
        tick();
        idle_inputs();
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("to e%0d res_valid", i), 32'(res_valid), 32'(i == 14));
            chk($sformatf("to e%0d busy", i), 32'(busy), 32'(i < 14));
            if (i == 1) chk("to issue inst_out", inst_out, 32'hC2202020);
            if (i == 14) begin
                chk("to res_err", 32'(res_err), 1);
                chk("to res_addr", res_addr, 0);
                chk("to res_data", res_data, 0);
            end
        end
        chk("to stray_wr", 32'(stray_wr), 0);

        // Burst: FIFO fills, ready stays low until the first pop, all issue back-to-back
        mon_val.delete();
        mon_cyc.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_kind  = 2'd0;
            req_inst  = 32'h8A000000 | i;
            tick();
        end
        chk("burst ready after 5th", 32'(req_ready), 0);
        req_inst = 32'h8A000005;
        tick();
        chk("burst ready held low", 32'(req_ready), 0);
        tick();
        chk("burst ready after pop", 32'(req_ready), 1);
        tick();
        idle_inputs();
        chk("burst ready refilled", 32'(req_ready), 0);
        c = 0;
        while (busy && c < 60) begin
            tick();
            c++;
        end
        chk("burst drained", 32'(busy), 0);
        mon_en = 1'b0;
        chk("burst issue count", mon_val.size(), 6);
        for (int i = 0; i < mon_val.size() && i < 6; i++) begin
            chk($sformatf("burst order %0d", i), mon_val[i], 32'h8A000000 | i);
            if (i > 0) chk($sformatf("burst spacing %0d", i), mon_cyc[i] - mon_cyc[i-1], 5);
        end

        // Reset during PAD with two entries queued
        mon_val.delete();
        mon_cyc.delete();
        mon_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            req_valid = 1'b1;
            req_kind  = (i == 1) ? 2'd2 : 2'd0;
            req_inst  = 32'h8B000000 | i;
            tick();
        end
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst mid inst_out", inst_out, NOP);
        chk("rst mid busy", 32'(busy), 0);
        chk("rst mid res_valid", 32'(res_valid), 0);
        chk("rst mid req_ready", 32'(req_ready), 1);
        n_rv = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_rv += 32'(res_valid);
        end
        mon_en = 1'b0;
        chk("rst mid no result", n_rv, 0);
        chk("rst mid issue count", mon_val.size(), 1);
        if (mon_val.size() > 0) chk("rst mid first issue", mon_val[0], 32'h8B000001);
        chk("rst mid idle busy", 32'(busy), 0);

        // Stray write in IDLE is sticky
        chk("stray before", 32'(stray_wr), 0);
        dmem_wr = 1'b1;
        dmem_addr = 32'h40000030;
        tick();
        dmem_wr = 1'b0;
        chk("stray set", 32'(stray_wr), 1);
        chk("stray no result", 32'(res_valid), 0);
        repeat (3) tick();
        chk("stray sticky", 32'(stray_wr), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
